// File: rtl/ew_line_scheduler_if.sv
// -----------------------------------------------------------------------------
// ew_line_scheduler_if
// Command/handshake bundle between the ElementWise line scheduler and the
// HBM read/write command engines plus the ElementWise datapath.
//
// Signals:
//   rd_cmd_valid/ready   read command handshake
//   rd_cmd_addr          line start address of the operand being read
//   rd_cmd_len           bytes in the line (W * PIXEL_BYTES)
//   rd_cmd_sel           0 = operand A, 1 = operand B
//   ew_mode              operation driven to the datapath (0 add, 1 minus, 2 mul)
//   ew_line_done         datapath has one output line buffered (pulse)
//   wr_cmd_valid/ready   write command handshake
//   wr_cmd_addr          output line address
//   wr_cmd_len           bytes in the line (W * PIXEL_BYTES)
//   wr_done              write of the current line completed (pulse)
//
// Modports: master = scheduler side, slave = engine/datapath side.
// -----------------------------------------------------------------------------
interface ew_line_scheduler_if #(
    parameter int ADDR_W = 32
);
    logic              rd_cmd_valid;
    logic              rd_cmd_ready;
    logic [ADDR_W-1:0] rd_cmd_addr;
    logic [31:0]       rd_cmd_len;
    logic              rd_cmd_sel;
    logic [1:0]        ew_mode;
    logic              ew_line_done;
    logic              wr_cmd_valid;
    logic              wr_cmd_ready;
    logic [ADDR_W-1:0] wr_cmd_addr;
    logic [31:0]       wr_cmd_len;
    logic              wr_done;

    modport master (
        output rd_cmd_valid, rd_cmd_addr, rd_cmd_len, rd_cmd_sel, ew_mode,
        output wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
        input  rd_cmd_ready, ew_line_done, wr_cmd_ready, wr_done
    );

    modport slave (
        input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len, rd_cmd_sel, ew_mode,
        input  wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
        output rd_cmd_ready, ew_line_done, wr_cmd_ready, wr_done
    );
endinterface

// File: rtl/ew_line_scheduler.sv
// -----------------------------------------------------------------------------
// ew_line_scheduler
// Hardware sequencer for one ElementWise operation (A op B -> Out) over an
// H x W x CH_div_Tout feature map, one pixel line at a time. For every line it
// issues a read of A, a read of B, waits for the datapath to finish the line,
// issues the write and waits for its completion.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 single-cycle pulse, latches all cfg_* inputs (IDLE only)
//   cfg_h/cfg_w/cfg_ch    map dimensions (H, W, CH_div_Tout)
//   cfg_mode              0 add, 1 minus, 2 mul, 3 reserved (error)
//   cfg_*_base            A, B and Out base addresses
//   cfg_in_surf/line      input surface and line strides
//   cfg_out_surf/line     output surface and line strides
//   bus                   command/handshake bundle (master side)
//   busy                  run in progress
//   done                  single-cycle completion pulse
//   err                   sticky: last accepted start had cfg_mode = 3
// -----------------------------------------------------------------------------
module ew_line_scheduler #(
    parameter int ADDR_W      = 32,
    parameter int DIM_W       = 16,
    parameter int PIXEL_BYTES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [DIM_W-1:0]  cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [ADDR_W-1:0] cfg_a_base,
    input  logic [ADDR_W-1:0] cfg_b_base,
    input  logic [ADDR_W-1:0] cfg_out_base,
    input  logic [ADDR_W-1:0] cfg_in_surf,
    input  logic [ADDR_W-1:0] cfg_in_line,
    input  logic [ADDR_W-1:0] cfg_out_surf,
    input  logic [ADDR_W-1:0] cfg_out_line,
    ew_line_scheduler_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_A    = 3'd1,
        S_RD_B    = 3'd2,
        S_WAIT_EW = 3'd3,
        S_WR      = 3'd4,
        S_WAIT_WR = 3'd5,
        S_NEXT    = 3'd6,
        S_FIN     = 3'd7
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Latched configuration
    logic [DIM_W-1:0]  r_cfg_h;
    logic [DIM_W-1:0]  r_cfg_ch;
    logic [1:0]        r_mode;
    logic [ADDR_W-1:0] r_a_base;
    logic [ADDR_W-1:0] r_b_base;
    logic [ADDR_W-1:0] r_out_base;
    logic [ADDR_W-1:0] r_in_surf;
    logic [ADDR_W-1:0] r_in_line;
    logic [ADDR_W-1:0] r_out_surf;
    logic [ADDR_W-1:0] r_out_line;
    logic [31:0]       r_len;

    // Loop counters and offset pointers (relative to the base addresses so a
    // single pointer pair serves both A and B reads).
    logic [DIM_W-1:0]  r_h;
    logic [DIM_W-1:0]  r_c;
    logic [ADDR_W-1:0] r_in_surf_ptr;
    logic [ADDR_W-1:0] r_in_line_ptr;
    logic [ADDR_W-1:0] r_out_surf_ptr;
    logic [ADDR_W-1:0] r_out_line_ptr;

    logic r_pend;   // ew_line_done seen while B read was still outstanding
    logic r_abort;  // run accepted with an empty map or reserved mode
    logic r_err;

    logic w_cfg_bad;
    logic w_last_h;
    logic w_last_c;
    logic w_accept;
    logic w_step;
    logic w_rd_valid;
    logic w_rd_sel;
    logic w_wr_valid;
    logic w_busy;
    logic w_done;

    assign w_cfg_bad = (cfg_h == '0) || (cfg_w == '0) || (cfg_ch == '0) ||
                       (cfg_mode == 2'd3);
    assign w_last_h  = (r_h == (r_cfg_h  - DIM_W'(1)));
    assign w_last_c  = (r_c == (r_cfg_ch - DIM_W'(1)));
    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_step    = (r_state == S_NEXT) && !r_abort && !(w_last_h && w_last_c);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_rd_valid   = 1'b0;
        w_rd_sel     = 1'b0;
        w_wr_valid   = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                // A rejected configuration still walks through NEXT so the
                // done pulse lands two cycles after start, like a normal run's
                // NEXT -> FIN tail.
                if (start) begin
                    w_state_next = w_cfg_bad ? S_NEXT : S_RD_A;
                end
            end
            S_RD_A: begin
                w_rd_valid = 1'b1;
                if (bus.rd_cmd_ready) begin
                    w_state_next = S_RD_B;
                end
            end
            S_RD_B: begin
                w_rd_valid = 1'b1;
                w_rd_sel   = 1'b1;
                // A line-done that arrived early (or arrives now) skips the
                // wait state entirely.
                if (bus.rd_cmd_ready) begin
                    w_state_next = (r_pend || bus.ew_line_done) ? S_WR : S_WAIT_EW;
                end
            end
            S_WAIT_EW: begin
                if (bus.ew_line_done || r_pend) begin
                    w_state_next = S_WR;
                end
            end
            S_WR: begin
                w_wr_valid = 1'b1;
                if (bus.wr_cmd_ready) begin
                    w_state_next = S_WAIT_WR;
                end
            end
            S_WAIT_WR: begin
                if (bus.wr_done) begin
                    w_state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                if (r_abort || (w_last_h && w_last_c)) begin
                    w_state_next = S_FIN;
                end else begin
                    w_state_next = S_RD_A;
                end
            end
            S_FIN: begin
                w_busy       = 1'b0;
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Early line-done capture: only armed while the B read is outstanding,
    // dropped once the handshake consumes it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
        end else if (r_state == S_RD_B) begin
            r_pend <= bus.rd_cmd_ready ? 1'b0 : (r_pend | bus.ew_line_done);
        end else begin
            r_pend <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Configuration latch, loop counters and incremental address pointers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_h        <= '0;
            r_cfg_ch       <= '0;
            r_mode         <= '0;
            r_a_base       <= '0;
            r_b_base       <= '0;
            r_out_base     <= '0;
            r_in_surf      <= '0;
            r_in_line      <= '0;
            r_out_surf     <= '0;
            r_out_line     <= '0;
            r_len          <= '0;
            r_h            <= '0;
            r_c            <= '0;
            r_in_surf_ptr  <= '0;
            r_in_line_ptr  <= '0;
            r_out_surf_ptr <= '0;
            r_out_line_ptr <= '0;
            r_abort        <= 1'b0;
            r_err          <= 1'b0;
        end else if (w_accept) begin
            r_cfg_h        <= cfg_h;
            r_cfg_ch       <= cfg_ch;
            r_mode         <= cfg_mode;
            r_a_base       <= cfg_a_base;
            r_b_base       <= cfg_b_base;
            r_out_base     <= cfg_out_base;
            r_in_surf      <= cfg_in_surf;
            r_in_line      <= cfg_in_line;
            r_out_surf     <= cfg_out_surf;
            r_out_line     <= cfg_out_line;
            r_len          <= 32'(cfg_w) * 32'(PIXEL_BYTES);
            r_h            <= '0;
            r_c            <= '0;
            r_in_surf_ptr  <= '0;
            r_in_line_ptr  <= '0;
            r_out_surf_ptr <= '0;
            r_out_line_ptr <= '0;
            r_abort        <= w_cfg_bad;
            r_err          <= (cfg_mode == 2'd3);
        end else if (w_step) begin
            if (w_last_h) begin
                // New channel surface: line pointer restarts at the new surface
                r_h            <= '0;
                r_c            <= r_c + DIM_W'(1);
                r_in_surf_ptr  <= r_in_surf_ptr  + r_in_surf;
                r_in_line_ptr  <= r_in_surf_ptr  + r_in_surf;
                r_out_surf_ptr <= r_out_surf_ptr + r_out_surf;
                r_out_line_ptr <= r_out_surf_ptr + r_out_surf;
            end else begin
                r_h            <= r_h + DIM_W'(1);
                r_in_line_ptr  <= r_in_line_ptr  + r_in_line;
                r_out_line_ptr <= r_out_line_ptr + r_out_line;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.rd_cmd_valid = w_rd_valid;
    assign bus.rd_cmd_sel   = w_rd_sel;
    assign bus.rd_cmd_addr  = (w_rd_sel ? r_b_base : r_a_base) + r_in_line_ptr;
    assign bus.rd_cmd_len   = r_len;
    assign bus.ew_mode      = r_mode;
    assign bus.wr_cmd_valid = w_wr_valid;
    assign bus.wr_cmd_addr  = r_out_base + r_out_line_ptr;
    assign bus.wr_cmd_len   = r_len;

    assign busy = w_busy;
    assign done = w_done;
    assign err  = r_err;

endmodule

// File: tb/tb_ew_line_scheduler.sv
// -----------------------------------------------------------------------------
// tb_ew_line_scheduler
// Directed bench for ew_line_scheduler: nominal map, read backpressure, early
// line-done capture, zero dimension, reserved mode, start while busy and reset
// in the middle of a run.
// -----------------------------------------------------------------------------
module tb_ew_line_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_h = '0, cfg_w = '0, cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [31:0] cfg_a_base = '0, cfg_b_base = '0, cfg_out_base = '0;
    logic [31:0] cfg_in_surf = '0, cfg_in_line = '0, cfg_out_surf = '0, cfg_out_line = '0;
    logic        busy, done, err;

    ew_line_scheduler_if #(.ADDR_W(32)) bus ();

    ew_line_scheduler #(.ADDR_W(32), .DIM_W(16), .PIXEL_BYTES(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_h        (cfg_h),
        .cfg_w        (cfg_w),
        .cfg_ch       (cfg_ch),
        .cfg_mode     (cfg_mode),
        .cfg_a_base   (cfg_a_base),
        .cfg_b_base   (cfg_b_base),
        .cfg_out_base (cfg_out_base),
        .cfg_in_surf  (cfg_in_surf),
        .cfg_in_line  (cfg_in_line),
        .cfg_out_surf (cfg_out_surf),
        .cfg_out_line (cfg_out_line),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Handshake monitor (read-only observation of the bus)
    int          n_rd_a = 0, n_rd_b = 0, n_wr = 0, n_done = 0;
    int          n_rdv = 0, n_wrv = 0, n_both = 0, n_len_bad = 0, n_mode_bad = 0;
    logic [31:0] last_a = '0, last_b = '0, last_w = '0;
    logic [31:0] exp_len = '0;
    logic [1:0]  exp_mode = '0;
    logic        busy_at_done = 1'b0;

    always @(posedge clk) begin
        if (bus.rd_cmd_valid) n_rdv++;
        if (bus.wr_cmd_valid) n_wrv++;
        if (bus.rd_cmd_valid && bus.wr_cmd_valid) n_both++;
        if (busy && bus.ew_mode !== exp_mode) n_mode_bad++;
        if (done) n_done++;
        if (bus.rd_cmd_valid && bus.rd_cmd_ready) begin
            if (bus.rd_cmd_sel) begin n_rd_b++; last_b = bus.rd_cmd_addr; end
            else                begin n_rd_a++; last_a = bus.rd_cmd_addr; end
            if (bus.rd_cmd_len !== exp_len) n_len_bad++;
            $display("tb: RD sel=%0d addr=0x%08h len=%0d", bus.rd_cmd_sel, bus.rd_cmd_addr, bus.rd_cmd_len);
        end
        if (bus.wr_cmd_valid && bus.wr_cmd_ready) begin
            n_wr++;
            last_w = bus.wr_cmd_addr;
            if (bus.wr_cmd_len !== exp_len) n_len_bad++;
            $display("tb: WR addr=0x%08h len=%0d", bus.wr_cmd_addr, bus.wr_cmd_len);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge; drives start with the given config for one cycle and
    // returns at the following negedge (first cycle after acceptance).
    task automatic do_start(input logic [15:0] h, w, ch, input logic [1:0] mode,
                            input logic [31:0] a, b, o, isurf, iline, osurf, oline);
        cfg_h = h; cfg_w = w; cfg_ch = ch; cfg_mode = mode;
        cfg_a_base = a; cfg_b_base = b; cfg_out_base = o;
        cfg_in_surf = isurf; cfg_in_line = iline; cfg_out_surf = osurf; cfg_out_line = oline;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("tb: START h=%0d w=%0d ch=%0d mode=%0d", h, w, ch, mode);
    endtask

    // Datapath/writer model, called at a negedge. Returns ew_line_done and
    // wr_done 'delay' cycles after the B read / write handshakes. Stops at the
    // done pulse, or (stop_wr != 0) one cycle after the stop_wr-th write
    // handshake, or when the cycle budget runs out.
    task automatic run_map(input int delay, input int stop_wr, input int budget,
                           output int cyc_wr_last, output int cyc_done, output bit got_done);
        int ew_t = 0;
        int wr_t = 0;
        int nw_local = 0;
        got_done = 1'b0;
        cyc_done = 0;
        cyc_wr_last = 0;
        for (int k = 0; k < budget; k++) begin
            bus.ew_line_done = 1'b0;
            bus.wr_done      = 1'b0;
            if (done) begin
                got_done = 1'b1;
                cyc_done = k;
                busy_at_done = busy;
                break;
            end
            if (stop_wr != 0 && nw_local == stop_wr) break;
            if (ew_t > 0) begin ew_t--; if (ew_t == 0) bus.ew_line_done = 1'b1; end
            if (wr_t > 0) begin wr_t--; if (wr_t == 0) begin bus.wr_done = 1'b1; cyc_wr_last = k; end end
            if (bus.rd_cmd_valid && bus.rd_cmd_sel && bus.rd_cmd_ready) ew_t = delay;
            if (bus.wr_cmd_valid && bus.wr_cmd_ready) begin wr_t = delay; nw_local++; end
            @(negedge clk);
        end
    endtask

    initial begin
        int  s_a, s_b, s_w, s_d, s_rdv, s_wrv, s_mb;
        int  cw, cd;
        bit  got;

        bus.rd_cmd_ready = 1'b1;
        bus.wr_cmd_ready = 1'b1;
        bus.ew_line_done = 1'b0;
        bus.wr_done      = 1'b0;

        // ---------------- Reset state ----------------
        repeat (2) @(negedge clk);
        chk("reset_rd_valid", 64'(bus.rd_cmd_valid), 64'd0);
        chk("reset_wr_valid", 64'(bus.wr_cmd_valid), 64'd0);
        chk("reset_busy_done_err", {61'd0, busy, done, err}, 64'd0);
        chk("reset_rd_addr", 64'(bus.rd_cmd_addr), 64'd0);
        chk("reset_len_mode", {30'd0, bus.rd_cmd_len, bus.ew_mode}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- Nominal run ----------------
        exp_len = 32'd2048; exp_mode = 2'd1;
        s_a = n_rd_a; s_b = n_rd_b; s_w = n_wr; s_d = n_done; s_mb = n_mode_bad;
        do_start(16'd5, 16'd64, 16'd4, 2'd1, 32'h0, 32'h0100_0000, 32'h0800_0000,
                 32'd10240, 32'd2048, 32'd10240, 32'd2048);
        chk("nom_first_rd", {30'd0, bus.rd_cmd_valid, bus.rd_cmd_sel, bus.rd_cmd_addr}, {30'd0, 2'b10, 32'h0});
        chk("nom_busy", 64'(busy), 64'd1);
        run_map(3, 0, 4000, cw, cd, got);
        chk("nom_got_done", 64'(got), 64'd1);
        chk("nom_rd_a_count", 64'(n_rd_a - s_a), 64'd20);
        chk("nom_rd_b_count", 64'(n_rd_b - s_b), 64'd20);
        chk("nom_wr_count", 64'(n_wr - s_w), 64'd20);
        chk("nom_len_bad", 64'(n_len_bad), 64'd0);
        chk("nom_last_a", 64'(last_a), 64'h9800);
        chk("nom_last_b", 64'(last_b), 64'h0100_9800);
        chk("nom_last_w", 64'(last_w), 64'h0800_9800);
        chk("nom_done_latency", 64'(cd - cw), 64'd2);
        chk("nom_busy_at_done", 64'(busy_at_done), 64'd0);
        chk("nom_mode_bad", 64'(n_mode_bad - s_mb), 64'd0);
        @(negedge clk);
        chk("nom_done_count", 64'(n_done - s_d), 64'd1);
        chk("nom_ew_mode_hold", 64'(bus.ew_mode), 64'd1);

        // ---------------- Backpressure on first A read ----------------
        exp_len = 32'd128; exp_mode = 2'd0;
        s_a = n_rd_a; s_b = n_rd_b; s_w = n_wr;
        bus.rd_cmd_ready = 1'b0;
        do_start(16'd2, 16'd4, 16'd1, 2'd0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                 32'd4096, 32'd128, 32'd4096, 32'd128);
        for (int i = 0; i < 7; i++) begin
            chk("bp_stall_stable", {30'd0, bus.rd_cmd_valid, bus.rd_cmd_sel, bus.rd_cmd_addr},
                {30'd0, 2'b10, 32'h0001_0000});
            if (i < 6) @(negedge clk);
        end
        chk("bp_no_handshake", 64'(n_rd_a - s_a), 64'd0);
        bus.rd_cmd_ready = 1'b1;
        @(negedge clk);
        chk("bp_b_after_a", {30'd0, bus.rd_cmd_valid, bus.rd_cmd_sel, bus.rd_cmd_addr},
            {30'd0, 2'b11, 32'h0002_0000});
        chk("bp_one_handshake", 64'(n_rd_a - s_a), 64'd1);
        run_map(3, 0, 500, cw, cd, got);
        chk("bp_got_done", 64'(got), 64'd1);
        chk("bp_counts", {16'd0, 16'(n_rd_a - s_a), 16'(n_rd_b - s_b), 16'(n_wr - s_w)},
            {16'd0, 16'd2, 16'd2, 16'd2});
        chk("bp_last_w", 64'(last_w), 64'h0003_0080);
        @(negedge clk);

        // ---------------- Early ew_line_done during RD_B ----------------
        exp_len = 32'd32; exp_mode = 2'd0;
        do_start(16'd1, 16'd1, 16'd1, 2'd0, 32'h100, 32'h200, 32'h300,
                 32'd64, 32'd32, 32'd64, 32'd32);
        @(negedge clk);
        chk("early_in_rd_b", {62'd0, bus.rd_cmd_valid, bus.rd_cmd_sel}, 64'd3);
        bus.rd_cmd_ready = 1'b0;
        bus.ew_line_done = 1'b1;
        @(negedge clk);
        bus.ew_line_done = 1'b0;
        chk("early_b_stalled", {62'd0, bus.rd_cmd_valid, bus.rd_cmd_sel}, 64'd3);
        bus.rd_cmd_ready = 1'b1;
        @(negedge clk);
        chk("early_wr_next_cycle", {62'd0, bus.rd_cmd_valid, bus.wr_cmd_valid}, 64'd1);
        chk("early_wr_addr", 64'(bus.wr_cmd_addr), 64'h300);
        run_map(3, 0, 200, cw, cd, got);
        chk("early_got_done", 64'(got), 64'd1);
        @(negedge clk);

        // ---------------- Zero dimension ----------------
        s_rdv = n_rdv; s_wrv = n_wrv; s_d = n_done;
        do_start(16'd5, 16'd0, 16'd4, 2'd0, 32'h0, 32'h0, 32'h0,
                 32'd0, 32'd0, 32'd0, 32'd0);
        chk("zero_done_not_yet", {62'd0, busy, done}, 64'd2);
        @(negedge clk);
        chk("zero_done_at_2", {62'd0, busy, done}, 64'd1);
        chk("zero_err_clear", 64'(err), 64'd0);
        @(negedge clk);
        chk("zero_no_cmds", {32'(n_rdv - s_rdv), 32'(n_wrv - s_wrv)}, 64'd0);
        chk("zero_done_count", 64'(n_done - s_d), 64'd1);

        // ---------------- Reserved mode ----------------
        s_rdv = n_rdv; s_wrv = n_wrv;
        exp_mode = 2'd3;
        do_start(16'd2, 16'd2, 16'd1, 2'd3, 32'h40, 32'h80, 32'hC0,
                 32'd128, 32'd64, 32'd128, 32'd64);
        @(negedge clk);
        chk("mode3_done_err", {62'd0, done, err}, 64'd3);
        @(negedge clk);
        chk("mode3_no_cmds", {32'(n_rdv - s_rdv), 32'(n_wrv - s_wrv)}, 64'd0);
        chk("mode3_err_sticky", 64'(err), 64'd1);

        // ---------------- Valid start clears err; start while busy ignored ----------------
        exp_len = 32'd32; exp_mode = 2'd2;
        s_a = n_rd_a; s_w = n_wr; s_mb = n_mode_bad;
        do_start(16'd1, 16'd1, 16'd1, 2'd2, 32'h100, 32'h200, 32'h300,
                 32'd64, 32'd32, 32'd64, 32'd32);
        chk("restart_err_cleared", 64'(err), 64'd0);
        chk("restart_mode", 64'(bus.ew_mode), 64'd2);
        cfg_mode = 2'd0; cfg_a_base = 32'h5555; cfg_b_base = 32'h6666; cfg_out_base = 32'h7777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_b_addr", {31'd0, bus.rd_cmd_sel, bus.rd_cmd_addr}, {31'd0, 1'b1, 32'h200});
        chk("busy_start_mode", 64'(bus.ew_mode), 64'd2);
        run_map(3, 0, 200, cw, cd, got);
        chk("busy_start_done", 64'(got), 64'd1);
        chk("busy_start_wr_addr", 64'(last_w), 64'h300);
        chk("busy_start_counts", {32'(n_rd_a - s_a), 32'(n_wr - s_w)}, {32'd1, 32'd1});
        chk("busy_start_mode_bad", 64'(n_mode_bad - s_mb), 64'd0);
        @(negedge clk);

        // ---------------- Reset during WAIT_WR of the third line ----------------
        exp_len = 32'd2048; exp_mode = 2'd1;
        do_start(16'd5, 16'd64, 16'd4, 2'd1, 32'h400, 32'h0100_0000, 32'h0800_0000,
                 32'd10240, 32'd2048, 32'd10240, 32'd2048);
        run_map(3, 3, 500, cw, cd, got);
        chk("rst_pre_waitwr", {61'd0, busy, bus.rd_cmd_valid, bus.wr_cmd_valid}, 64'd4);
        s_d = n_done;
        rst_n = 1'b0;
        #1;
        chk("rst_valids", {62'd0, bus.rd_cmd_valid, bus.wr_cmd_valid}, 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        chk("rst_addrs", {bus.rd_cmd_addr, bus.wr_cmd_addr}, 64'd0);
        chk("rst_len_mode", {30'd0, bus.wr_cmd_len, bus.ew_mode}, 64'd0);
        repeat (3) @(negedge clk);
        chk("rst_no_done", 64'(n_done - s_d), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        s_a = n_rd_a; s_b = n_rd_b; s_w = n_wr; s_d = n_done;
        do_start(16'd5, 16'd64, 16'd4, 2'd1, 32'h400, 32'h0100_0000, 32'h0800_0000,
                 32'd10240, 32'd2048, 32'd10240, 32'd2048);
        chk("rerun_first_rd", {30'd0, bus.rd_cmd_valid, bus.rd_cmd_sel, bus.rd_cmd_addr},
            {30'd0, 2'b10, 32'h400});
        run_map(3, 0, 4000, cw, cd, got);
        chk("rerun_got_done", 64'(got), 64'd1);
        chk("rerun_counts", {16'd0, 16'(n_rd_a - s_a), 16'(n_rd_b - s_b), 16'(n_wr - s_w)},
            {16'd0, 16'd20, 16'd20, 16'd20});
        chk("rerun_last_a", 64'(last_a), 64'h9C00);
        @(negedge clk);
        chk("rerun_done_count", 64'(n_done - s_d), 64'd1);
        chk("never_both_valid", 64'(n_both), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
